ex_mem_stage_reg: RTL and testbench
===================================

Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline stage register, successor to the fixed-width version.
- Adds valid/ready handshake, an optional 2-entry skid buffer, synchronous flush (bubble insertion), async active-low reset, and control gating on invalid slots.
- Sits between the ALU/branch-compare stage and data-memory access. Upstream may stall it, and the hazard unit may flush it.

Parameters:
- DATA_W, 32, width of ALU result and store-data operand
- ADDR_W, 11, width of branch/jump destination address
- REG_W, 5, width of destination register index
- CTRL_W, 5, width of control bundle; bit map [0]MemToReg [1]RegWrite [2]MemRead [3]MemWrite [4]Branch
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX stage presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- result_in  in  DATA_W  ALU result
- registro_2_in  in  DATA_W  second register operand (store data)
- jump_dest_addr_in  in  ADDR_W  branch target
- zero_signal_in  in  1  ALU zero flag
- reg_dest_in  in  REG_W  destination register
- ctrl_in  in  CTRL_W  control bundle
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM stage accepts
- result_out, registro_2_out, jump_dest_addr_out, zero_signal_out, reg_dest_out  out  matching widths  head-entry payload
- ctrl_out  out  CTRL_W  head-entry control, gated by out_valid
- occupancy  out  2  number of held entries (0..2)

Behaviour:
- Reset (reset_n low, async): all entries invalid, all payload registers 0, out_valid=0, ctrl_out=0, occupancy=0. in_ready=1 when SKID_EN=1. Reset applies mid-transfer with no partial writes.
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready. Everything is sampled on the rising edge of clock.
- SKID_EN=1 state machine, with H = head, S = skid:
  - EMPTY:
    - in -> ONE (H loaded).
  - ONE:
    - in & out -> ONE (H reloaded).
    - in only -> FULL (S loaded).
    - out only -> EMPTY.
  - FULL:
    - out -> ONE (S moves to H in the same edge). in_ready is 0 in FULL, so no input is taken.
  - in_ready = (state != FULL), driven from a register with no combinational path from out_ready.
- SKID_EN=0: single entry. in_ready = ~out_valid | out_ready (combinational). occupancy is never 2.
- Latency: input accepted at edge N appears on the outputs after edge N (1 cycle). Sustained throughput is 1 per cycle while out_ready=1.
- Ordering is strict FIFO. No entry is ever dropped or duplicated.
- flush=1:
  - At the next edge all entries become invalid, state=EMPTY, occupancy=0.
  - An input offered in the same cycle is discarded even if in_valid & in_ready.
  - flush has priority over in and out. An out transfer in the flush cycle still counts as consumed by MEM.
- ctrl_out = out_valid ? H.ctrl : 0, so a bubble never asserts RegWrite/MemWrite/MemRead/Branch.
- Data outputs hold the last H contents when invalid. They are not cleared except by reset.
- Payload registers load only on an accepting transfer. No clock-enable glitching, and no X propagation from an idle in_valid=0 bus.
- Stall (out_ready=0, out_valid=1): all outputs must be stable, bit-for-bit, until consumed.
- Widths are pure passthrough, with no arithmetic. Parameter changes must not alter timing behaviour.

Test Plan:
- Reset then stream: assert reset_n=0 mid-stream while FULL, release, then send 4 back-to-back entries (result_in 0x11,0x22,0x33,0x44, ctrl_in 5'b00011) with out_ready=1. Required: out_valid rises 1 cycle after the first accept, outputs appear in order one per cycle, occupancy stays at 1, in_ready stays 1, and post-reset ctrl_out=0.
- Backpressure/skid (SKID_EN=1): hold out_ready=0 and send 0xA0, 0xA1, 0xA2. Required: 0xA0 and 0xA1 accepted, in_ready=0 the cycle after the 2nd accept, occupancy=2, 0xA2 held by the source. Release out_ready: outputs 0xA0, 0xA1, 0xA2 in order with no loss.
- Flush with simultaneous input: FULL (0xB0, 0xB1), then flush=1 while in_valid=1 with 0xB2. Required: next cycle out_valid=0, ctrl_out=0, occupancy=0, in_ready=1, and 0xB2 never appears.
- Bubble gating: in_valid=0 while ctrl_in=5'b11111 and reset/idle. Required: ctrl_out stays 5'b00000 and out_valid=0. Then one entry with MemWrite (ctrl 5'b01000): ctrl_out=5'b01000 for exactly its valid cycles.
- Single-entry mode (SKID_EN=0, DATA_W=64, ADDR_W=16): alternate out_ready 1/0 across 6 inputs. Required: in_ready equals ~out_valid|out_ready every cycle, occupancy ≤1, 64-bit payload 0xDEADBEEF_CAFEF00D arrives intact.
- Simultaneous in/out in ONE state: stream 0xC0..0xC7 with out_ready=1 continuously. Required: each output exactly 1 cycle after its accept, and occupancy never reaches 2.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register: valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and control gating so an empty slot never drives memory/regfile controls.
module ex_mem_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int REG_W   = 5,
  parameter int CTRL_W  = 5,
  parameter int SKID_EN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] registro_2_in,
  input  logic [ADDR_W-1:0] jump_dest_addr_in,
  input  logic              zero_signal_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] registro_2_out,
  output logic [ADDR_W-1:0] jump_dest_addr_out,
  output logic              zero_signal_out,
  output logic [REG_W-1:0]  reg_dest_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [1:0]        occupancy
);

  // state    | meaning
  // ST_EMPTY | no entry held
  // ST_ONE   | head entry valid
  // ST_FULL  | head and skid entries valid (skid mode only)
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;

  localparam int PW = CTRL_W + REG_W + 1 + ADDR_W + 2 * DATA_W;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_head, r_skid, w_in_pl;
  logic [CTRL_W-1:0] w_h_ctrl;
  logic            w_in_xfer, w_out_xfer;
  logic            w_load_h_in, w_load_h_s, w_load_s;

  assign w_in_pl = {ctrl_in, reg_dest_in, zero_signal_in, jump_dest_addr_in,
                    registro_2_in, result_in};
  assign {w_h_ctrl, reg_dest_out, zero_signal_out, jump_dest_addr_out,
          registro_2_out, result_out} = r_head;

  assign out_valid  = (r_state != ST_EMPTY);
  assign occupancy  = r_state;
  assign ctrl_out   = out_valid ? w_h_ctrl : '0;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_h_in = 1'b0;
    w_load_h_s  = 1'b0;
    w_load_s    = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_load_h_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_h_in = 1'b1;
          end else if (w_in_xfer && (SKID_EN != 0)) begin
            w_state_nxt = ST_FULL;
            w_load_s    = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt = ST_ONE;
            w_load_h_s  = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_h_in)     r_head <= w_in_pl;
      else if (w_load_h_s) r_head <= r_skid;
      if (w_load_s)        r_skid <= w_in_pl;
    end
  end

  // Skid mode registers in_ready so out_ready has no combinational path to the EX stage.
  generate
    if (SKID_EN != 0) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_in_ready <= 1'b1;
        else          r_in_ready <= (w_state_nxt != ST_FULL);
      end
      assign in_ready = r_in_ready;
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: table-driven handshake vectors with a payload scoreboard on the
// skid instance, plus hand-written reset and single-entry (64-bit) sequences.
module tb_ex_mem_stage_reg;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // skid instance (default parameters)
  logic        in_valid, in_ready, flush, out_valid, out_ready, zero_in, zero_out;
  logic [31:0] result_in, reg2_in, result_out, reg2_out;
  logic [10:0] jump_in, jump_out;
  logic [4:0]  dest_in, dest_out, ctrl_in, ctrl_out;
  logic [1:0]  occupancy;

  // single-entry 64-bit instance
  logic        d1_in_valid, d1_in_ready, d1_flush, d1_out_valid, d1_out_ready, d1_zero_out;
  logic [63:0] d1_result_in, d1_reg2_in, d1_result_out, d1_reg2_out;
  logic [15:0] d1_jump_in, d1_jump_out;
  logic [4:0]  d1_dest_out, d1_ctrl_out;
  logic [1:0]  d1_occupancy;

  ex_mem_stage_reg u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .result_in(result_in), .registro_2_in(reg2_in), .jump_dest_addr_in(jump_in),
    .zero_signal_in(zero_in), .reg_dest_in(dest_in), .ctrl_in(ctrl_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
    .registro_2_out(reg2_out), .jump_dest_addr_out(jump_out), .zero_signal_out(zero_out),
    .reg_dest_out(dest_out), .ctrl_out(ctrl_out), .occupancy(occupancy)
  );

  ex_mem_stage_reg #(.DATA_W(64), .ADDR_W(16), .SKID_EN(0)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .result_in(d1_result_in), .registro_2_in(d1_reg2_in), .jump_dest_addr_in(d1_jump_in),
    .zero_signal_in(1'b1), .reg_dest_in(5'd7), .ctrl_in(5'b00011), .flush(d1_flush),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .result_out(d1_result_out),
    .registro_2_out(d1_reg2_out), .jump_dest_addr_out(d1_jump_out),
    .zero_signal_out(d1_zero_out), .reg_dest_out(d1_dest_out), .ctrl_out(d1_ctrl_out),
    .occupancy(d1_occupancy)
  );

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] res;
    logic [4:0]  ctrl;
    logic [1:0]  e_occ;
    logic        e_ir, e_ov;
  } vec_t;

  typedef struct {
    logic [31:0] res, r2;
    logic [10:0] jd;
    logic        z;
    logic [4:0]  rd, ctrl;
  } pl_t;

  vec_t  vecs[$];
  pl_t   sb[$];
  logic [63:0] sb64[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic pl_t mk(input logic [31:0] r, input logic [4:0] c);
    pl_t p;
    p.res  = r;
    p.r2   = ~r;
    p.jd   = r[10:0] ^ 11'h555;
    p.z    = r[0];
    p.rd   = r[4:0] ^ 5'h0A;
    p.ctrl = c;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic ordy, input logic fl, input logic [31:0] res,
                     input logic [4:0] ctrl, input logic [1:0] occ, input logic ir,
                     input logic ov);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.res = res; v.ctrl = ctrl;
    v.e_occ = occ; v.e_ir = ir; v.e_ov = ov;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] r,
                       input logic [4:0] c);
    pl_t p;
    p = mk(r, c);
    in_valid = iv; out_ready = ordy; flush = fl;
    result_in = p.res; reg2_in = p.r2; jump_in = p.jd; zero_in = p.z;
    dest_in = p.rd; ctrl_in = p.ctrl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pl_t  p;
    int   m_occ, sent;
    logic exp_ir, out_x, in_x;
    logic [63:0] r64;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
    d1_in_valid = 0; d1_out_ready = 0; d1_flush = 0;
    d1_result_in = '0; d1_reg2_in = '0; d1_jump_in = '0;

    // stream
    add(1,1,0,32'h11,5'h03,0,1,0); add(1,1,0,32'h22,5'h03,1,1,1);
    add(1,1,0,32'h33,5'h03,1,1,1); add(1,1,0,32'h44,5'h03,1,1,1);
    add(0,1,0,32'h00,5'h00,1,1,1); add(0,0,0,32'h00,5'h00,0,1,0);
    // backpressure into the skid entry
    add(1,0,0,32'hA0,5'h02,0,1,0); add(1,0,0,32'hA1,5'h02,1,1,1);
    add(1,0,0,32'hA2,5'h02,2,0,1); add(1,0,0,32'hA2,5'h02,2,0,1);
    add(1,1,0,32'hA2,5'h02,2,0,1); add(1,1,0,32'hA2,5'h02,1,1,1);
    add(0,1,0,32'h00,5'h00,1,1,1); add(0,0,0,32'h00,5'h00,0,1,0);
    // flush from FULL, from ONE with in_ready=1, and with a concurrent out transfer
    add(1,0,0,32'hB0,5'h03,0,1,0); add(1,0,0,32'hB1,5'h03,1,1,1);
    add(1,0,1,32'hB2,5'h03,2,0,1); add(0,0,0,32'h00,5'h00,0,1,0);
    add(1,0,0,32'hB3,5'h03,0,1,0); add(1,0,1,32'hB2,5'h03,1,1,1);
    add(0,1,0,32'h00,5'h00,0,1,0); add(1,1,0,32'hB4,5'h03,0,1,0);
    add(1,1,1,32'hB5,5'h03,1,1,1); add(0,1,0,32'h00,5'h00,0,1,0);
    // bubble gating
    add(0,1,0,32'hFF,5'h1F,0,1,0); add(0,1,0,32'hFF,5'h1F,0,1,0);
    add(1,0,0,32'hE0,5'h08,0,1,0); add(0,0,0,32'hFF,5'h1F,1,1,1);
    add(0,1,0,32'hFF,5'h1F,1,1,1); add(0,1,0,32'hFF,5'h1F,0,1,0);
    // continuous flow through ONE
    for (int i = 0; i < 8; i++)
      add(1,1,0,32'hC0 + 32'(i),5'h03,(i == 0) ? 2'd0 : 2'd1,1,(i != 0));
    add(0,1,0,32'h00,5'h00,1,1,1); add(0,1,0,32'h00,5'h00,0,1,0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
    reset_n = 1'b1;

    // fill to FULL, then reset asynchronously mid-cycle
    @(posedge clock); #1 drive(1'b1, 1'b0, 1'b0, 32'h91, 5'h1F);
    @(posedge clock); #1 drive(1'b1, 1'b0, 1'b0, 32'h92, 5'h1F);
    @(posedge clock); #1 drive(1'b1, 1'b0, 1'b0, 32'h93, 5'h1F);
    @(negedge clock);
    check("pre_rst_occ", 64'(occupancy), 64'd2);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_occ", 64'(occupancy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_ctrl_out", 64'(ctrl_out), 64'd0);
    check("midrst_result", 64'(result_out), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
    @(negedge clock) reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clock);
      #1 drive(vecs[k].iv, vecs[k].ordy, vecs[k].fl, vecs[k].res, vecs[k].ctrl);
      @(negedge clock);
      check($sformatf("v%0d_occ", k), 64'(occupancy), 64'(vecs[k].e_occ));
      check($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].e_ir));
      check($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].e_ov));
      if (vecs[k].e_ov) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL v%0d_scoreboard: got empty queue expected an entry", k);
        end else begin
          p = sb[0];
          check($sformatf("v%0d_result", k), 64'(result_out), 64'(p.res));
          check($sformatf("v%0d_reg2", k), 64'(reg2_out), 64'(p.r2));
          check($sformatf("v%0d_jump", k), 64'(jump_out), 64'(p.jd));
          check($sformatf("v%0d_zero", k), 64'(zero_out), 64'(p.z));
          check($sformatf("v%0d_dest", k), 64'(dest_out), 64'(p.rd));
          check($sformatf("v%0d_ctrl", k), 64'(ctrl_out), 64'(p.ctrl));
        end
      end else begin
        check($sformatf("v%0d_ctrl_gated", k), 64'(ctrl_out), 64'd0);
      end
      if (vecs[k].e_ov && vecs[k].ordy && sb.size() != 0) void'(sb.pop_front());
      if (vecs[k].fl) sb.delete();
      else if (vecs[k].iv && vecs[k].e_ir) sb.push_back(mk(vecs[k].res, vecs[k].ctrl));
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    // single-entry 64-bit instance, out_ready alternating
    m_occ = 0; sent = 0;
    for (int c = 0; c < 40 && (sent < 6 || m_occ != 0); c++) begin
      @(posedge clock);
      #1;
      d1_out_ready = (c % 2 == 0);
      d1_in_valid  = (sent < 6);
      d1_result_in = 64'hDEADBEEF_CAFEF00D + 64'(sent) * 64'h0101_0101_0000_0000;
      d1_reg2_in   = ~d1_result_in;
      d1_jump_in   = d1_result_in[15:0] ^ 16'h5A5A;
      @(negedge clock);
      exp_ir = (m_occ == 0) | d1_out_ready;
      check($sformatf("s%0d_in_ready", c), 64'(d1_in_ready), 64'(exp_ir));
      check($sformatf("s%0d_occ", c), 64'(d1_occupancy), 64'(m_occ));
      check($sformatf("s%0d_out_valid", c), 64'(d1_out_valid), 64'(m_occ != 0));
      if (m_occ != 0 && sb64.size() != 0) begin
        r64 = sb64[0];
        check($sformatf("s%0d_result64", c), d1_result_out, r64);
        check($sformatf("s%0d_reg2_64", c), d1_reg2_out, ~r64);
        check($sformatf("s%0d_jump16", c), 64'(d1_jump_out), 64'(r64[15:0] ^ 16'h5A5A));
        check($sformatf("s%0d_ctrl", c), 64'(d1_ctrl_out), 64'h03);
      end
      out_x = (m_occ != 0) && d1_out_ready;
      in_x  = d1_in_valid && exp_ir;
      if (out_x && sb64.size() != 0) void'(sb64.pop_front());
      if (in_x) begin
        sb64.push_back(d1_result_in);
        sent++;
      end
      m_occ = m_occ - int'(out_x) + int'(in_x);
    end
    check("single_sent", 64'(sent), 64'd6);
    check("single_drained", 64'(m_occ), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
